// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, two combinational read ports.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_W:0]   cnt_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reservation is applied after the write-clear so the newer producer wins;
  // flush overrides both.
  always_comb begin
    busy_next = busy;
    if (wr_en)  busy_next[wr_addr]  = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
    if (flush)  busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    busy1    = busy[rd_addr1];
    if (wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0)) begin
      rd_data1 = wr_data;
      busy1    = rsv_en && (rsv_addr == rd_addr1);
    end
  end

  always_comb begin
    rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
    busy2    = busy[rd_addr2];
    if (wr_en && (wr_addr == rd_addr2) && (rd_addr2 != '0)) begin
      rd_data2 = wr_data;
      busy2    = rsv_en && (rsv_addr == rd_addr2);
    end
  end
`else
  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
    busy1    = busy[rd_addr1];
    busy2    = busy[rd_addr2];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb; inputs change on the falling
// edge and outputs are checked just before the following rising edge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic        busy1, busy2;
  logic [5:0]  busy_cnt;

  int applied = 0;
  int miscompares = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_busy1;
    logic        exp_busy2;
    logic [5:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(string name, logic rst, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic re, logic [4:0] ra, logic fl,
                              logic [4:0] a1, logic [4:0] a2, logic [31:0] d1,
                              logic [31:0] d2, logic b1, logic b2, logic [5:0] cnt);
    vec_t v;
    v.name = name; v.reset = rst; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rsv_en = re; v.rsv_addr = ra; v.flush = fl; v.rd_addr1 = a1; v.rd_addr2 = a2;
    v.exp_rd1 = d1; v.exp_rd2 = d2; v.exp_busy1 = b1; v.exp_busy2 = b2; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset    = v.reset;
    wr_en    = v.wr_en;
    wr_addr  = v.wr_addr;
    wr_data  = v.wr_data;
    rsv_en   = v.rsv_en;
    rsv_addr = v.rsv_addr;
    flush    = v.flush;
    rd_addr1 = v.rd_addr1;
    rd_addr2 = v.rd_addr2;
  endtask

  task automatic checkOutput(input vec_t v);
    applied++;
    if (rd_data1 !== v.exp_rd1) begin
      miscompares++;
      $display("[TB] FAIL %s rd_data1: got %h expected %h", v.name, rd_data1, v.exp_rd1);
    end
    if (rd_data2 !== v.exp_rd2) begin
      miscompares++;
      $display("[TB] FAIL %s rd_data2: got %h expected %h", v.name, rd_data2, v.exp_rd2);
    end
    if (busy1 !== v.exp_busy1) begin
      miscompares++;
      $display("[TB] FAIL %s busy1: got %b expected %b", v.name, busy1, v.exp_busy1);
    end
    if (busy2 !== v.exp_busy2) begin
      miscompares++;
      $display("[TB] FAIL %s busy2: got %b expected %b", v.name, busy2, v.exp_busy2);
    end
    if (busy_cnt !== v.exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL %s busy_cnt: got %0d expected %0d", v.name, busy_cnt, v.exp_cnt);
    end
  endtask

  task automatic runVector(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #4;
    checkOutput(v);
  endtask

  vec_t table_v[$];
  vec_t v;
  logic [31:0] byp_d;
  logic        byp_b;

  initial begin
    // Columns: name, reset, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    //          rd_addr1, rd_addr2, exp_rd1, exp_rd2, exp_busy1, exp_busy2, exp_cnt
    table_v.push_back(mk("reset_read",   1,0, 0,32'h0,        0, 0,0,  5,31, 32'h0,        32'h0,  0,0,0));
    table_v.push_back(mk("wr7",          1,1, 7,32'hDEADBEEF, 0, 0,0,  5,31, 32'h0,        32'h0,  0,0,0));
    table_v.push_back(mk("rd7_wr0",      1,1, 0,32'h12345678, 0, 0,0,  7, 0, 32'hDEADBEEF, 32'h0,  0,0,0));
    table_v.push_back(mk("rsv3_rd0",     1,0, 0,32'h0,        1, 3,0,  0, 0, 32'h0,        32'h0,  0,0,0));
    table_v.push_back(mk("rsv4",         1,0, 0,32'h0,        1, 4,0,  3, 4, 32'h0,        32'h0,  1,0,1));
    table_v.push_back(mk("wr3",          1,1, 3,32'h11,       0, 0,0,  4, 7, 32'h0,        32'hDEADBEEF, 1,0,2));
    table_v.push_back(mk("after_wr3",    1,0, 0,32'h0,        0, 0,0,  3, 4, 32'h11,       32'h0,  0,1,1));
    table_v.push_back(mk("rsv4_again",   1,0, 0,32'h0,        1, 4,0,  4, 3, 32'h0,        32'h11, 1,0,1));
    table_v.push_back(mk("wr7_notbusy",  1,1, 7,32'h77,       0, 0,0,  4, 3, 32'h0,        32'h11, 1,0,1));
    table_v.push_back(mk("rsv_wr9",      1,1, 9,32'h99,       1, 9,0,  4, 7, 32'h0,        32'h77, 1,0,1));
    table_v.push_back(mk("after_rsvwr9", 1,0, 0,32'h0,        0, 0,0,  9, 4, 32'h99,       32'h0,  1,1,2));
    table_v.push_back(mk("rsv9_flush",   1,0, 0,32'h0,        1, 9,1,  9, 4, 32'h99,       32'h0,  1,1,2));
    table_v.push_back(mk("after_flush",  1,0, 0,32'h0,        0, 0,0,  9, 4, 32'h99,       32'h0,  0,0,0));
    table_v.push_back(mk("flush_wr20",   1,1,20,32'h20,       1,20,1,  9, 3, 32'h99,       32'h11, 0,0,0));
    table_v.push_back(mk("after_fwr20",  1,0, 0,32'h0,        0, 0,0, 20,31, 32'h20,       32'h0,  0,0,0));
    table_v.push_back(mk("rsv0",         1,0, 0,32'h0,        1, 0,0,  0,20, 32'h0,        32'h20, 0,0,0));
    table_v.push_back(mk("after_rsv0",   1,0, 0,32'h0,        0, 0,0,  0, 0, 32'h0,        32'h0,  0,0,0));

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    @(posedge clk);

    foreach (table_v[i]) runVector(table_v[i]);

    // Write-through sequence on register 12 (reserved first so busy is visible)
    runVector(mk("byp_pre_wr",  1,1,12,32'h1212, 0, 0,0,  0, 0, 32'h0, 32'h0, 0,0,0));
    runVector(mk("byp_rsv12",   1,0, 0,32'h0,    1,12,0, 12, 0, 32'h1212, 32'h0, 0,0,0));
`ifdef REGFILE_SB_BYPASS_EN
    byp_d = 32'hA5A5A5A5; byp_b = 1'b0;
`else
    byp_d = 32'h1212;     byp_b = 1'b1;
`endif
    runVector(mk("byp_same",    1,1,12,32'hA5A5A5A5, 0, 0,0, 12, 0, byp_d, 32'h0, byp_b,0,1));
    runVector(mk("byp_next",    1,0, 0,32'h0,    0, 0,0, 12, 0, 32'hA5A5A5A5, 32'h0, 0,0,0));

    // Reserve every non-zero index, then reset with a write in flight
    for (int i = 1; i < 32; i++) begin
      v = mk("rsv_fill", 1,0,0,32'h0, 1,5'(i),0, 0,0, 32'h0,32'h0, 0,0,6'(i-1));
      runVector(v);
    end
    runVector(mk("full_cnt",    1,0, 0,32'h0,    1, 7,0,  1,31, 32'h0, 32'h0, 1,1,31));
    runVector(mk("reset_mid",   0,1, 5,32'hFFFF, 1, 2,1,  1,31, 32'h0, 32'h0, 1,1,31));
    runVector(mk("post_reset1", 1,0, 0,32'h0,    0, 0,0,  7,12, 32'h0, 32'h0, 0,0,0));
    runVector(mk("post_reset2", 1,0, 0,32'h0,    0, 0,0,  5, 9, 32'h0, 32'h0, 0,0,0));
    runVector(mk("post_reset3", 1,0, 0,32'h0,    0, 0,0, 31, 3, 32'h0, 32'h0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
